// File: rtl/alarm_controller.sv
// Alarm sequencing FSM: debounces the sensor trip line and runs the
// disarmed / exit-delay / armed / entry-delay / alarm cycle.
module alarm_controller #(
  parameter int EXIT_DELAY  = 16,
  parameter int ENTRY_DELAY = 16,
  parameter int SIREN_TIME  = 64,
  parameter int DEBOUNCE    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arm_req,
  input  logic       disarm_req,
  input  logic       sensor_y,
  input  logic [3:0] zone_in,
  output logic       siren,
  output logic       warn,
  output logic       armed,
  output logic [2:0] state_o,
  output logic [3:0] latched_zone,
  output logic [7:0] alarm_cnt
);

  typedef enum logic [2:0] {
    S_DISARMED = 3'd0,
    S_EXIT     = 3'd1,
    S_ARMED    = 3'd2,
    S_ENTRY    = 3'd3,
    S_ALARM    = 3'd4
  } state_t;

  localparam int MAX_P = (EXIT_DELAY > ENTRY_DELAY)
                         ? ((EXIT_DELAY > SIREN_TIME) ? EXIT_DELAY : SIREN_TIME)
                         : ((ENTRY_DELAY > SIREN_TIME) ? ENTRY_DELAY : SIREN_TIME);
  localparam int TW = (MAX_P > 1) ? $clog2(MAX_P) : 1;
  localparam int CW = $clog2(DEBOUNCE + 1);

  localparam logic [TW-1:0] EXIT_LOAD  = TW'(EXIT_DELAY - 1);
  localparam logic [TW-1:0] ENTRY_LOAD = TW'(ENTRY_DELAY - 1);
  localparam logic [TW-1:0] SIREN_LOAD = TW'(SIREN_TIME - 1);
  localparam logic [CW-1:0] DB_MAX     = CW'(DEBOUNCE);

  state_t        state, next_state;
  logic [TW-1:0] timer;
  logic [CW-1:0] db_cnt;
  logic          trip;
  logic          expiry;

  assign trip   = (db_cnt == DB_MAX);
  assign expiry = (timer == '0);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of the order the blocks are evaluated.
  always_ff @(posedge clk) begin
    if (rst) state <= S_DISARMED;
    else     state <= next_state;
  end

  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      S_DISARMED: if (arm_req && !disarm_req) next_state = S_EXIT;
      S_EXIT: begin
        if (disarm_req)  next_state = S_DISARMED;
        else if (expiry) next_state = S_ARMED;
      end
      S_ARMED: begin
        if (disarm_req) next_state = S_DISARMED;
        else if (trip)  next_state = S_ENTRY;
      end
      S_ENTRY: begin
        if (disarm_req)  next_state = S_DISARMED;
        else if (expiry) next_state = S_ALARM;
      end
      S_ALARM: begin
        if (disarm_req)  next_state = S_DISARMED;
        else if (expiry) next_state = S_ARMED;
      end
      default: next_state = S_DISARMED;
    endcase
  end

  // Datapath registers follow the transitions chosen above; the debounce
  // counter runs in every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer        <= '0;
      db_cnt       <= '0;
      latched_zone <= '0;
      alarm_cnt    <= '0;
    end else begin
      if (!sensor_y)           db_cnt <= '0;
      else if (db_cnt != DB_MAX) db_cnt <= db_cnt + 1'b1;

      if (next_state != state) begin
        case (next_state)
          S_EXIT:  timer <= EXIT_LOAD;
          S_ENTRY: timer <= ENTRY_LOAD;
          S_ALARM: timer <= SIREN_LOAD;
          default: timer <= '0;
        endcase
      end else if (timer != '0) begin
        timer <= timer - 1'b1;
      end

      if (state == S_DISARMED && next_state == S_EXIT)
        latched_zone <= '0;
      else if (state == S_ARMED && next_state == S_ENTRY)
        latched_zone <= zone_in;

      if (state == S_ENTRY && next_state == S_ALARM && alarm_cnt != 8'hFF)
        alarm_cnt <= alarm_cnt + 8'd1;
    end
  end

  always_comb begin
    siren   = (state == S_ALARM);
    warn    = (state == S_EXIT) || (state == S_ENTRY);
    armed   = (state == S_ARMED) || (state == S_ENTRY) || (state == S_ALARM);
    state_o = state;
  end

endmodule
